// File: rtl/qspi_flash_stub.sv
// QSPI NOR-flash slave model (0x03/0x6B/0x05/0x9F); QSPI_FLASH_STUB_PROGRAM_EN adds 0x06/0x04/0x02.
// Latency: SCK/CS seen ~2 clk late; qspi_io_i updates 1 clk after a detected SCK fall.
// Backpressure: none; the master must hold each SCK phase for >=2 clk.
module qspi_flash_stub #(
  parameter int          MEM_BYTES    = 65536,
  parameter string       INIT_FILE    = "",
  parameter int          DUMMY_CYCLES = 8,
  parameter logic [23:0] JEDEC_ID     = 24'hEF4018
) (
  input  logic       clk,
  input  logic       rst,
  output logic [3:0] qspi_io_i,
  input  logic [3:0] qspi_io_o,
  input  logic [3:0] qspi_io_t,
  input  logic       qspi_ck_o,
  input  logic       qspi_cs_o
);

  localparam int AW = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DUMMY,
    ST_DATA1,
    ST_DATA4,
    ST_STAT,
    ST_ID,
    ST_PROG,
    ST_IGNORE
  } state_t;

  logic [7:0]    mem [MEM_BYTES];

  state_t        state;
  logic          ck_s, ck_p, cs_s, cs_p, din_s;
  logic [7:0]    cmd;
  logic [7:0]    cnt;
  logic [22:0]   shreg;
  logic [AW-1:0] addr;
  logic [2:0]    out_cnt;
  logic          nib_lo;
  logic [1:0]    id_idx;
  logic          wel;

  logic          ck_rise, ck_fall, cs_fall;
  logic [7:0]    cur8;
  logic [AW-1:0] addr_load, addr_inc;
  logic [7:0]    rd_byte;
  logic          unused_io;

  assign unused_io = ^{qspi_io_t, qspi_io_o[3:1]};

  initial begin
    for (int i = 0; i < MEM_BYTES; i++) mem[i] <= i[7:0];
  end

  assign ck_rise   = ck_s & ~ck_p;
  assign ck_fall   = ~ck_s & ck_p;
  assign cs_fall   = ~cs_s & cs_p;
  assign cur8      = {shreg[6:0], din_s};
  assign addr_load = AW'({8'd0, shreg, din_s} % 32'(MEM_BYTES));
  assign addr_inc  = (addr == AW'(MEM_BYTES - 1)) ? '0 : addr + 1'b1;

  always_comb begin
    rd_byte = mem[addr];
    case (state)
      ST_STAT: rd_byte = {6'b0, wel, 1'b0};
      ST_ID: begin
        case (id_idx)
          2'd0:    rd_byte = JEDEC_ID[23:16];
          2'd1:    rd_byte = JEDEC_ID[15:8];
          2'd2:    rd_byte = JEDEC_ID[7:0];
          default: rd_byte = 8'hFF;
        endcase
      end
      default: ;
    endcase
  end

`ifdef QSPI_FLASH_STUB_PROGRAM_EN
  logic          prog_we;
  logic [AW-1:0] addr_pg;

  // Program pointer stays inside the current 256-byte page.
  assign addr_pg = (addr & ~AW'(255)) | ((addr + 1'b1) & AW'(255));
  assign prog_we = (state == ST_PROG) && !cs_s && !cs_fall && ck_rise && (cnt == 8'd7);

  always @(posedge clk) begin
    if (prog_we) mem[addr] <= mem[addr] & cur8;
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ck_s      <= 1'b0;
      ck_p      <= 1'b0;
      cs_s      <= 1'b1;
      cs_p      <= 1'b1;
      din_s     <= 1'b0;
      state     <= ST_IDLE;
      cmd       <= 8'h00;
      cnt       <= 8'd0;
      shreg     <= '0;
      addr      <= '0;
      out_cnt   <= 3'd7;
      nib_lo    <= 1'b0;
      id_idx    <= 2'd0;
      wel       <= 1'b0;
      qspi_io_i <= 4'hF;
    end else begin
      ck_s  <= qspi_ck_o;
      ck_p  <= ck_s;
      cs_s  <= qspi_cs_o;
      cs_p  <= cs_s;
      din_s <= qspi_io_o[0];

      if (cs_s) begin
        // Deselect aborts everything; a partially shifted byte is simply dropped.
        state     <= ST_IDLE;
        cnt       <= 8'd0;
        qspi_io_i <= 4'hF;
`ifdef QSPI_FLASH_STUB_PROGRAM_EN
        if (cmd == 8'h02 && (state == ST_ADDR || state == ST_PROG)) wel <= 1'b0;
`endif
      end else if (cs_fall) begin
        state     <= ST_CMD;
        cnt       <= 8'd0;
        qspi_io_i <= 4'hF;
      end else if (ck_rise) begin
        shreg <= {shreg[21:0], din_s};
        cnt   <= cnt + 8'd1;
        case (state)
          ST_CMD: begin
            if (cnt == 8'd7) begin
              cnt     <= 8'd0;
              cmd     <= cur8;
              out_cnt <= 3'd7;
              nib_lo  <= 1'b0;
              id_idx  <= 2'd0;
              case (cur8)
                8'h03, 8'h6B: state <= ST_ADDR;
                8'h05:        state <= ST_STAT;
                8'h9F:        state <= ST_ID;
`ifdef QSPI_FLASH_STUB_PROGRAM_EN
                8'h06: begin
                  wel   <= 1'b1;
                  state <= ST_IGNORE;
                end
                8'h04: begin
                  wel   <= 1'b0;
                  state <= ST_IGNORE;
                end
                8'h02:        state <= wel ? ST_ADDR : ST_IGNORE;
`endif
                default:      state <= ST_IGNORE;
              endcase
            end
          end
          ST_ADDR: begin
            if (cnt == 8'd23) begin
              cnt  <= 8'd0;
              addr <= addr_load;
              if (cmd == 8'h6B)      state <= (DUMMY_CYCLES == 0) ? ST_DATA4 : ST_DUMMY;
              else if (cmd == 8'h02) state <= ST_PROG;
              else                   state <= ST_DATA1;
            end
          end
          ST_DUMMY: begin
            if (32'(cnt) == DUMMY_CYCLES - 1) begin
              cnt   <= 8'd0;
              state <= ST_DATA4;
            end
          end
`ifdef QSPI_FLASH_STUB_PROGRAM_EN
          ST_PROG: begin
            if (cnt == 8'd7) begin
              cnt  <= 8'd0;
              addr <= addr_pg;
            end
          end
`endif
          default: ;
        endcase
      end else if (ck_fall) begin
        case (state)
          ST_DATA1, ST_STAT, ST_ID: begin
            qspi_io_i <= {2'b11, rd_byte[out_cnt], 1'b1};
            out_cnt   <= out_cnt - 3'd1;
            if (out_cnt == 3'd0) begin
              if (state == ST_DATA1) addr <= addr_inc;
              if (state == ST_ID && id_idx != 2'd3) id_idx <= id_idx + 2'd1;
            end
          end
          ST_DATA4: begin
            qspi_io_i <= nib_lo ? rd_byte[3:0] : rd_byte[7:4];
            nib_lo    <= ~nib_lo;
            if (nib_lo) addr <= addr_inc;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_qspi_flash_stub.sv
// Randomized bench for qspi_flash_stub acting as a QSPI master against a flat byte-array flash model.
module tb_qspi_flash_stub;

  localparam int MEM_BYTES = 65536;
  localparam int DUMMY     = 8;
  localparam int HALF      = 3;
`ifdef QSPI_FLASH_STUB_PROGRAM_EN
  localparam bit PROG_EN = 1'b1;
`else
  localparam bit PROG_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] qspi_io_i;
  logic [3:0] qspi_io_o;
  logic [3:0] qspi_io_t;
  logic       qspi_ck_o;
  logic       qspi_cs_o;

  logic [7:0] mem_m [MEM_BYTES];
  logic       wel_m;
  int         n_checks;
  int         n_fail;

  always #5 clk = ~clk;

  qspi_flash_stub #(
    .MEM_BYTES   (MEM_BYTES),
    .INIT_FILE   (""),
    .DUMMY_CYCLES(DUMMY),
    .JEDEC_ID    (24'hEF4018)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .qspi_io_i(qspi_io_i),
    .qspi_io_o(qspi_io_o),
    .qspi_io_t(qspi_io_t),
    .qspi_ck_o(qspi_ck_o),
    .qspi_cs_o(qspi_cs_o)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One SCK period; io is what the flash presents just before the rising edge.
  task automatic spi_bit(input logic b, output logic [3:0] io);
    qspi_io_o = {3'($urandom), b};
    qspi_io_t = 4'($urandom);
    wait_clk(HALF);
    io = qspi_io_i;
    qspi_ck_o = 1'b1;
    wait_clk(HALF);
    qspi_ck_o = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic [3:0] io;
    for (int i = 7; i >= 0; i--) spi_bit(b[i], io);
  endtask

  task automatic send_addr(input logic [23:0] a);
    send_byte(a[23:16]);
    send_byte(a[15:8]);
    send_byte(a[7:0]);
  endtask

  task automatic recv_byte(output logic [7:0] b, output logic side_ok);
    logic [3:0] io;
    side_ok = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      spi_bit(1'($urandom), io);
      b[i] = io[1];
      if ({io[3:2], io[0]} != 3'b111) side_ok = 1'b0;
    end
  endtask

  task automatic cs_begin();
    qspi_cs_o = 1'b0;
    wait_clk(HALF);
  endtask

  task automatic cs_end();
    qspi_cs_o = 1'b1;
    wait_clk(2 * HALF);
  endtask

  task automatic send_cmd(input logic [7:0] c);
    cs_begin();
    send_byte(c);
    cs_end();
    if (c == 8'h06) wel_m = PROG_EN;
    if (c == 8'h04) wel_m = 1'b0;
  endtask

  task automatic do_read(input logic [7:0] c, input logic [23:0] a, input int nbytes, input string tag);
    int         base;
    logic [7:0] b;
    logic [3:0] io, hi, lo, dmy;
    logic       ok;
    base = int'(a) % MEM_BYTES;
    cs_begin();
    send_byte(c);
    send_addr(a);
    if (c == 8'h6B) begin
      dmy = 4'hF;
      for (int i = 0; i < DUMMY; i++) begin
        spi_bit(1'($urandom), io);
        dmy = dmy & io;
      end
      check_eq({tag, "_dummy"}, dmy, 4'hF);
    end
    for (int k = 0; k < nbytes; k++) begin
      if (c == 8'h6B) begin
        spi_bit(1'($urandom), hi);
        spi_bit(1'($urandom), lo);
        b = {hi, lo};
      end else begin
        recv_byte(b, ok);
        check_eq($sformatf("%s_side%0d", tag, k), ok, 1'b1);
      end
      check_eq($sformatf("%s[%0d]", tag, k), b, mem_m[(base + k) % MEM_BYTES]);
    end
    cs_end();
  endtask

  task automatic read_stat(input string tag);
    logic [7:0] b;
    logic       ok;
    cs_begin();
    send_byte(8'h05);
    for (int k = 0; k < 2; k++) begin
      recv_byte(b, ok);
      check_eq($sformatf("%s[%0d]", tag, k), b, {6'b0, wel_m, 1'b0});
    end
    cs_end();
  endtask

  task automatic do_prog(input logic [23:0] a, input logic [7:0] d0, input logic [7:0] d1, input int n);
    int page, off;
    page = (int'(a) % MEM_BYTES) & ~255;
    off  = int'(a) & 255;
    cs_begin();
    send_byte(8'h02);
    send_addr(a);
    send_byte(d0);
    if (n > 1) send_byte(d1);
    cs_end();
    if (PROG_EN && wel_m) begin
      mem_m[page + off] = mem_m[page + off] & d0;
      if (n > 1) mem_m[page + ((off + 1) & 255)] = mem_m[page + ((off + 1) & 255)] & d1;
      wel_m = 1'b0;
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog expired checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  b;
    logic [7:0]  id_exp [5];
    logic [3:0]  io, part, any_io;
    logic [23:0] a;
    logic        ok;
    n_checks = 0;
    n_fail   = 0;
    for (int i = 0; i < MEM_BYTES; i++) mem_m[i] = i[7:0];
    wel_m = 1'b0;
    id_exp = '{8'hEF, 8'h40, 8'h18, 8'hFF, 8'hFF};

    rst = 1'b0;
    qspi_cs_o = 1'b1;
    qspi_ck_o = 1'b0;
    qspi_io_o = 4'h0;
    qspi_io_t = 4'hF;
    wait_clk(4);
    check_eq("reset_io", qspi_io_i, 4'hF);
    rst = 1'b1;
    wait_clk(2);
    for (int i = 0; i < 12; i++) begin
      qspi_ck_o = ~qspi_ck_o;
      qspi_io_o = 4'($urandom);
      wait_clk(2);
    end
    qspi_ck_o = 1'b0;
    wait_clk(2);
    check_eq("sck_cs_high_io", qspi_io_i, 4'hF);

    do_read(8'h03, 24'h000010, 2, "rd03");
    do_read(8'h6B, 24'h00FFFF, 2, "rd6b_wrap");

    cs_begin();
    send_byte(8'h9F);
    for (int k = 0; k < 5; k++) begin
      recv_byte(b, ok);
      check_eq($sformatf("jedec[%0d]", k), b, id_exp[k]);
    end
    cs_end();

    read_stat("stat0");
    send_cmd(8'h06);
    read_stat("stat_wren");
    do_prog(24'h000020, 8'h0F, 8'h00, 1);
    do_read(8'h03, 24'h000020, 1, "prog_rd");
    read_stat("stat_after_prog");
    send_cmd(8'h06);
    send_cmd(8'h04);
    read_stat("stat_wrdi");
    do_prog(24'h000030, 8'h00, 8'h00, 1);
    do_read(8'h03, 24'h000030, 1, "prog_nowel");
    send_cmd(8'h06);
    do_prog(24'h0001FF, 8'h3C, 8'hF0, 2);
    do_read(8'h03, 24'h0001FF, 2, "prog_page_end");
    do_read(8'h03, 24'h000100, 1, "prog_page_wrap");

    // Deselect after half a data byte, then re-read the same address.
    a = 24'h001234;
    cs_begin();
    send_byte(8'h03);
    send_addr(a);
    for (int i = 3; i >= 0; i--) begin
      spi_bit(1'b0, io);
      part[i] = io[1];
    end
    cs_end();
    check_eq("abort_partial", part, mem_m[int'(a)][7:4]);
    do_read(8'h03, a, 2, "abort_reread");

    cs_begin();
    send_byte(8'hAB);
    any_io = 4'hF;
    for (int i = 0; i < 16; i++) begin
      spi_bit(1'($urandom), io);
      any_io = any_io & io;
    end
    check_eq("unknown_cmd_io", any_io, 4'hF);
    check_eq("unknown_cmd_last", io, 4'hF);
    cs_end();

    cs_begin();
    send_byte(8'h03);
    send_addr(24'h000555);
    for (int i = 0; i < 3; i++) spi_bit(1'b0, io);
    rst = 1'b0;
    qspi_cs_o = 1'b1;
    wait_clk(3);
    check_eq("midreset_io", qspi_io_i, 4'hF);
    rst = 1'b1;
    wait_clk(4);
    check_eq("post_reset_io", qspi_io_i, 4'hF);
    do_read(8'h03, 24'h000555, 1, "post_reset_rd");

    for (int it = 0; it < 16; it++) begin
      a = 24'($urandom);
      if ($urandom_range(0, 2) == 0) a[15:0] = 16'hFFFF - 16'($urandom_range(0, 2));
      do_read(($urandom_range(0, 1) == 0) ? 8'h03 : 8'h6B, a, $urandom_range(1, 3),
              $sformatf("rand%0d", it));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
